mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Multicycle memory-port sequencer between the control FSM and a shared instruction/data memory with a req/ack handshake. Converts the control unit's one-cycle fetch, load and store strobes into held memory transactions. Captures the fetched instruction with its PC, and the loaded word. Asserts a stall while a transaction is open and reports a RISC-V access-fault cause on handshake timeout.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, cycles of req without ack before abort (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_fetch  in  1  fetch strobe (fetch state, IRWrite)
- start_read  in  1  load strobe (memread state, AdrSrc=1, MemWrite=0)
- start_write  in  1  store strobe (memwrite state, MemWrite=1)
- addr  in  ADDR_W  transaction address, sampled at accept
- wdata  in  DATA_W  store data, sampled at accept
- pc_in  in  ADDR_W  current PC, sampled on fetch accept
- err_clr  in  1  clears sticky fault
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  write enable, valid while mem_req
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered store data
- mem_ack  in  1  memory completion; rdata valid in the same cycle
- mem_rdata  in  DATA_W  read data
- instr  out  DATA_W  instruction register
- old_pc  out  ADDR_W  PC of instr
- rdata  out  DATA_W  load data register
- busy  out  1  stall to control FSM
- done  out  1  one-cycle completion pulse
- fault  out  1  sticky timeout fault
- fault_cause  out  4  1 = fetch, 5 = load, 7 = store access fault; 0 when none

## Operation
- States: IDLE, ISSUE, COMPLETE, ABORT.
- IDLE: a start accepted only here. Priority: fetch > write > read. Accept registers addr, the selected kind, and wdata (write) or pc_in (fetch). Clears wait counter. Goes to ISSUE.
- Starts while not IDLE are ignored; they are not queued.
- ISSUE:
  - mem_req=1; mem_we=1 only for write.
  - mem_ack=1: fetch loads instr←mem_rdata and old_pc←captured PC; read loads rdata←mem_rdata; write updates no data register. Goes to COMPLETE.
  - No ack: counter increments. On the cycle the counter equals TIMEOUT-1 with no ack, goes to ABORT.
  - Ack on that same cycle wins; the transaction completes normally.
- COMPLETE: done=1 for one cycle, then IDLE.
- ABORT: fault←1 and fault_cause←kind code, then IDLE. instr/rdata keep their old values. No done pulse.
- fault/fault_cause are sticky until err_clr. A new abort overwrites the cause. err_clr and a new abort in the same cycle: the abort wins.
- mem_ack outside ISSUE is ignored.
- busy = (state != IDLE) or (a start is accepted this cycle). This is combinational so the FSM stalls from the strobe cycle.
- Reset value of every output is 0: mem_req, mem_we, mem_addr, mem_wdata, instr, old_pc, rdata, done, fault, fault_cause, busy (with no start). State returns to IDLE. Reset mid-transaction drops mem_req immediately and discards data.

## Timing
- Start accepted at edge N → mem_req high in cycle N+1.
- Ack in cycle M → data registers updated at edge M; done high in cycle M+1; IDLE in cycle M+2.
- Zero-wait memory (ack in the first ISSUE cycle): start-to-done = 2 cycles, back-to-back start possible every 3 cycles.
- mem_addr, mem_we and mem_wdata are stable for the whole of mem_req.
- Timeout: with no ack, mem_req is high exactly TIMEOUT cycles, then ABORT is held 1 cycle. fault is visible TIMEOUT+2 cycles after accept.
- All outputs except busy are registered.

## Test plan
- Fetch, addr=0x0000_0010, pc_in=0x10, ack on the first req cycle with rdata=0x0050_0093 → instr=0x0050_0093, old_pc=0x10, done in cycle 3, busy cycles 1–3.
- Store, addr=0x0000_0100, wdata=0xDEAD_BEEF, ack after 3 wait cycles → mem_we=1 and mem_wdata stable for 4 req cycles; rdata and instr unchanged; one done pulse.
- start_fetch and start_read in the same cycle → only the fetch is issued (mem_we=0, instr updated); the read is dropped; a start_read during ISSUE is ignored.
- Load with no ack, TIMEOUT=15 → mem_req high 15 cycles, fault=1, fault_cause=5, no done. err_clr → fault=0, fault_cause=0. Ack in cycle 15 instead → normal completion, no fault.
- rst_n low mid-ISSUE → mem_req=0 asynchronously, all outputs 0. After release, a fetch completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multicycle memory-port sequencer: turns one-cycle fetch/load/store strobes into
// held req/ack transactions, captures instruction/load data, flags timeouts.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_fetch,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] old_pc,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [3:0]        fault_cause
);

  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE, ABORT} state_t;
  typedef enum logic [1:0] {K_FETCH, K_READ, K_WRITE} kind_t;

  state_t            state;
  kind_t             kind;
  logic [ADDR_W-1:0] pc_reg;
  logic [7:0]        wait_cnt;
  logic              accept;

  // busy is combinational so the control FSM stalls in the strobe cycle itself
  assign accept = (state == IDLE) && (start_fetch || start_read || start_write);
  assign busy   = (state != IDLE) || accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      kind        <= K_FETCH;
      pc_reg      <= '0;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      instr       <= '0;
      old_pc      <= '0;
      rdata       <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 4'd0;
    end else begin
      done <= 1'b0;
      if (err_clr) begin
        fault       <= 1'b0;
        fault_cause <= 4'd0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr <= addr;
            mem_req  <= 1'b1;
            wait_cnt <= '0;
            state    <= ISSUE;
            if (start_fetch) begin
              kind   <= K_FETCH;
              pc_reg <= pc_in;
              mem_we <= 1'b0;
            end else if (start_write) begin
              kind      <= K_WRITE;
              mem_wdata <= wdata;
              mem_we    <= 1'b1;
            end else begin
              kind   <= K_READ;
              mem_we <= 1'b0;
            end
          end
        end
        ISSUE: begin
          // an ack on the final wait cycle still beats the timeout
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= COMPLETE;
            if (kind == K_FETCH) begin
              instr  <= mem_rdata;
              old_pc <= pc_reg;
            end else if (kind == K_READ) begin
              rdata <= mem_rdata;
            end
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= ABORT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        COMPLETE: state <= IDLE;
        ABORT: begin
          fault <= 1'b1;
          case (kind)
            K_FETCH: fault_cause <= 4'd1;
            K_READ:  fault_cause <= 4'd5;
            default: fault_cause <= 4'd7;
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: handshake timing, priority,
// timeout faults and asynchronous reset.
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_fetch, start_read, start_write, err_clr, mem_ack;
  logic [31:0] addr, wdata, pc_in, mem_rdata;
  logic        mem_req, mem_we, busy, done, fault;
  logic [31:0] mem_addr, mem_wdata, instr, old_pc, rdata;
  logic [3:0]  fault_cause;

  int vectors = 0;
  int miscompares = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_fetch(start_fetch), .start_read(start_read), .start_write(start_write),
    .addr(addr), .wdata(wdata), .pc_in(pc_in), .err_clr(err_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .old_pc(old_pc), .rdata(rdata),
    .busy(busy), .done(done), .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_fetch = 0; start_read = 0; start_write = 0; err_clr = 0;
    mem_ack = 0; addr = '0; wdata = '0; pc_in = '0; mem_rdata = '0;
    #12;
    vectors++;
    if ({mem_req, mem_we, busy, done, fault} !== 5'b0) begin
      miscompares++; $display("[TB] FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, busy, done, fault});
    end
    vectors++;
    if ((mem_addr | mem_wdata | instr | old_pc | rdata | 32'(fault_cause)) !== 32'h0) begin
      miscompares++; $display("[TB] FAIL reset_data: got nonzero data outputs, want 0");
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    start_fetch = 1; addr = 32'h10; pc_in = 32'h10;
    #1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL fetch_busy_c1: got %b want 1", busy); end
    tick();
    start_fetch = 0;
    vectors++;
    if ({mem_req, mem_we, busy} !== 3'b101 || mem_addr !== 32'h10) begin
      miscompares++; $display("[TB] FAIL fetch_issue: got req/we/busy %b addr %h want 101 00000010", {mem_req, mem_we, busy}, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 0;
    vectors++;
    if ({done, busy, mem_req} !== 3'b110) begin
      miscompares++; $display("[TB] FAIL fetch_done_c3: got done/busy/req %b want 110", {done, busy, mem_req});
    end
    vectors++;
    if (instr !== 32'h0050_0093 || old_pc !== 32'h10) begin
      miscompares++; $display("[TB] FAIL fetch_data: got instr %h pc %h want 00500093 00000010", instr, old_pc);
    end
    tick();
    vectors++;
    if ({done, busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL fetch_idle: got done/busy %b want 00", {done, busy}); end
  endtask

  task automatic test_store();
    start_write = 1; addr = 32'h100; wdata = 32'hDEAD_BEEF;
    tick();
    start_write = 0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({mem_req, mem_we} !== 2'b11 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h100 || done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL store_hold[%0d]: got req/we %b wdata %h addr %h done %b want 11 deadbeef 00000100 0", i, {mem_req, mem_we}, mem_wdata, mem_addr, done);
      end
      if (i == 3) begin mem_ack = 1; mem_rdata = 32'h5555_AAAA; end
      tick();
    end
    mem_ack = 0;
    vectors++;
    if ({done, mem_req} !== 2'b10) begin miscompares++; $display("[TB] FAIL store_done: got done/req %b want 10", {done, mem_req}); end
    vectors++;
    if (rdata !== 32'h0 || instr !== 32'h0050_0093) begin
      miscompares++; $display("[TB] FAIL store_regs: got rdata %h instr %h want 00000000 00500093", rdata, instr);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL store_one_pulse: got %b want 0", done); end
  endtask

  task automatic test_priority();
    start_fetch = 1; start_read = 1; addr = 32'h20; pc_in = 32'h20;
    tick();
    start_fetch = 0;
    addr = 32'h999;
    vectors++;
    if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h20) begin
      miscompares++; $display("[TB] FAIL prio_issue: got req/we %b addr %h want 10 00000020", {mem_req, mem_we}, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 0; start_read = 0;
    vectors++;
    if (instr !== 32'h1234_5678 || old_pc !== 32'h20 || rdata !== 32'h0 || done !== 1'b1) begin
      miscompares++; $display("[TB] FAIL prio_fetch_won: got instr %h pc %h rdata %h done %b want 12345678 00000020 00000000 1", instr, old_pc, rdata, done);
    end
    tick();
    tick();
    vectors++;
    if ({mem_req, busy} !== 2'b00) begin miscompares++; $display("[TB] FAIL prio_read_dropped: got req/busy %b want 00", {mem_req, busy}); end
  endtask

  task automatic test_timeout();
    int n = 0;
    int done_seen = 0;
    start_read = 1; addr = 32'h40;
    tick();
    start_read = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      if (done === 1'b1) done_seen++;
      tick();
    end
    vectors++;
    if (n !== TO) begin miscompares++; $display("[TB] FAIL timeout_req_len: got %0d want %0d", n, TO); end
    tick();
    vectors++;
    if ({fault, fault_cause} !== 5'b1_0101 || done !== 1'b0 || done_seen !== 0) begin
      miscompares++; $display("[TB] FAIL timeout_fault: got fault %b cause %0d done %b seen %0d want 1 5 0 0", fault, fault_cause, done, done_seen);
    end
    vectors++;
    if (rdata !== 32'h0 || busy !== 1'b0) begin
      miscompares++; $display("[TB] FAIL timeout_regs: got rdata %h busy %b want 00000000 0", rdata, busy);
    end
    tick();
    vectors++;
    if (fault !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_sticky: got %b want 1", fault); end
    err_clr = 1;
    tick();
    err_clr = 0;
    vectors++;
    if ({fault, fault_cause} !== 5'b0) begin
      miscompares++; $display("[TB] FAIL err_clr: got fault %b cause %0d want 0 0", fault, fault_cause);
    end
  endtask

  task automatic test_ack_last();
    start_read = 1; addr = 32'h44;
    tick();
    start_read = 0;
    for (int i = 0; i < TO - 1; i++) tick();
    vectors++;
    if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL ack_last_req: got %b want 1", mem_req); end
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 0;
    vectors++;
    if (done !== 1'b1 || rdata !== 32'hCAFE_F00D) begin
      miscompares++; $display("[TB] FAIL ack_last_done: got done %b rdata %h want 1 cafef00d", done, rdata);
    end
    tick();
    tick();
    vectors++;
    if ({fault, fault_cause} !== 5'b0) begin
      miscompares++; $display("[TB] FAIL ack_last_nofault: got fault %b cause %0d want 0 0", fault, fault_cause);
    end
  endtask

  task automatic test_reset_mid();
    start_fetch = 1; addr = 32'h80; pc_in = 32'h80;
    tick();
    start_fetch = 0;
    vectors++;
    if (mem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid_pre: got %b want 1", mem_req); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_req, mem_we, busy, done, fault} !== 5'b0 || (mem_addr | instr | old_pc | rdata) !== 32'h0) begin
      miscompares++; $display("[TB] FAIL rst_mid_async: got req %b addr %h instr %h rdata %h want all 0", mem_req, mem_addr, instr, rdata);
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_fetch = 1; addr = 32'h84; pc_in = 32'h84;
    tick();
    start_fetch = 0;
    mem_ack = 1; mem_rdata = 32'h0000_0013;
    tick();
    mem_ack = 0;
    vectors++;
    if (done !== 1'b1 || instr !== 32'h13 || old_pc !== 32'h84) begin
      miscompares++; $display("[TB] FAIL rst_mid_refetch: got done %b instr %h pc %h want 1 00000013 00000084", done, instr, old_pc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_timeout();
    test_ack_last();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
